idli_sqi_shift_m: RTL and testbench

IDLI_SQI_SHIFT_M -- requirements
Module: idli_sqi_shift_m

---
 rtl/idli_pkg.sv | 13 +
 rtl/idli_nib_ctr_m.sv | 27 ++
 rtl/idli_sqi_shift_m.sv | 155 +++++++++++++++
 tb/tb_idli_sqi_shift_m.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared state encoding and default word width for the idli SQI nibble shifter.
package idli_pkg;

  localparam int IDLI_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    RX   = 2'd2,
    TX   = 2'd3
  } sqr_state_t;

endpackage

// File: rtl/idli_nib_ctr_m.sv
// Loadable down-counter with stall hold and zero flag; counts nibbles and turnaround cycles.
module idli_nib_ctr_m #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && !o_zero) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/idli_sqi_shift_m.sv
// SQI nibble shifter: parallel word <-> 4-bit serial stream in either nibble order.
// Receive turnaround (TURN state) is built only when IDLI_SQI_SHIFT_TURN_EN is defined.
module idli_sqi_shift_m
  import idli_pkg::*;
#(
  parameter int  DATA_W   = IDLI_DATA_W,
  parameter int  TURN_CYC = 2,
  localparam int CNT_W    = $clog2(DATA_W/4)
) (
  input  logic              i_sqr_gck,
  input  logic              i_sqr_rst,
  input  logic              i_sqr_start,
  input  logic              i_sqr_dir,
  input  logic              i_sqr_big,
  input  logic [CNT_W-1:0]  i_sqr_len,
  input  logic [DATA_W-1:0] i_sqr_pdata,
  input  logic [3:0]        i_sqr_sio,
  input  logic              i_sqr_stall,
  output logic [3:0]        o_sqr_sio,
  output logic              o_sqr_sio_oe,
  output logic              o_sqr_ready,
  output logic              o_sqr_done,
  output logic [DATA_W-1:0] o_sqr_pdata
);

  localparam int               TURN_W  = $clog2(TURN_CYC + 1);
  localparam int               CTR_W   = (CNT_W > TURN_W) ? CNT_W : TURN_W;
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(DATA_W/4 - 1);

  sqr_state_t        r_state;
  sqr_state_t        w_state_nxt;
  logic              r_big;
  logic              r_done;
  logic [CNT_W-1:0]  r_len;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_pdata;

  logic              w_accept;
  logic              w_adv;
  logic              w_fin;
  logic              w_ctr_load;
  logic              w_ctr_dec;
  logic              w_ctr_zero;
  logic [CTR_W-1:0]  w_ctr_val;
  logic [CNT_W+1:0]  w_tx_pad;
  logic [CNT_W+1:0]  w_rx_pad;
  logic [DATA_W-1:0] w_rx_nxt;
  logic [DATA_W-1:0] w_rx_res;

  assign w_adv    = ~i_sqr_stall;
  assign w_accept = (r_state == IDLE) && i_sqr_start;

  // Unused high nibbles, in bits: big-endian TX left-aligns, little-endian RX right-aligns.
  assign w_tx_pad = {LEN_MAX - i_sqr_len, 2'b00};
  assign w_rx_pad = {LEN_MAX - r_len, 2'b00};
  assign w_rx_nxt = r_big ? {r_shift[DATA_W-5:0], i_sqr_sio}
                          : {i_sqr_sio, r_shift[DATA_W-1:4]};
  assign w_rx_res = r_big ? w_rx_nxt : (w_rx_nxt >> w_rx_pad);

  always_comb begin
    w_state_nxt = r_state;
    w_ctr_load  = 1'b0;
    w_ctr_val   = '0;
    w_ctr_dec   = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_sqr_start) begin
          w_ctr_load = 1'b1;
          w_ctr_val  = CTR_W'(i_sqr_len);
          if (i_sqr_dir) begin
            w_state_nxt = TX;
`ifdef IDLI_SQI_SHIFT_TURN_EN
          end else if (TURN_CYC > 0) begin
            w_state_nxt = TURN;
            w_ctr_val   = CTR_W'(TURN_CYC - 1);
`endif
          end else begin
            w_state_nxt = RX;
          end
        end
      end
      TURN: begin
`ifdef IDLI_SQI_SHIFT_TURN_EN
        if (w_adv) begin
          if (w_ctr_zero) begin
            w_state_nxt = RX;
            w_ctr_load  = 1'b1;
            w_ctr_val   = CTR_W'(r_len);
          end else begin
            w_ctr_dec = 1'b1;
          end
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      RX, TX: begin
        if (w_adv) begin
          if (w_ctr_zero) begin
            w_state_nxt = IDLE;
            w_fin       = 1'b1;
          end else begin
            w_ctr_dec = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_sqr_gck) begin
    if (i_sqr_rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_big   <= 1'b0;
      r_len   <= '0;
      r_shift <= '0;
      r_pdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_fin;
      if (w_accept) begin
        r_big   <= i_sqr_big;
        r_len   <= i_sqr_len;
        r_shift <= i_sqr_dir ? (i_sqr_big ? (i_sqr_pdata << w_tx_pad) : i_sqr_pdata) : '0;
      end else if (w_adv && (r_state == TX)) begin
        r_shift <= r_big ? (r_shift << 4) : (r_shift >> 4);
      end else if (w_adv && (r_state == RX)) begin
        r_shift <= w_rx_nxt;
      end
      if (w_fin && (r_state == RX)) begin
        r_pdata <= w_rx_res;
      end
    end
  end

  idli_nib_ctr_m #(
    .W (CTR_W)
  ) u_nib_ctr (
    .i_clk      (i_sqr_gck),
    .i_rst      (i_sqr_rst),
    .i_load     (w_ctr_load),
    .i_load_val (w_ctr_val),
    .i_dec      (w_ctr_dec),
    .o_zero     (w_ctr_zero)
  );

  assign o_sqr_ready  = (r_state == IDLE);
  assign o_sqr_sio_oe = (r_state == TX);
  assign o_sqr_sio    = o_sqr_sio_oe ? (r_big ? r_shift[DATA_W-1 -: 4] : r_shift[3:0]) : 4'h0;
  assign o_sqr_done   = r_done;
  assign o_sqr_pdata  = r_pdata;

endmodule

// File: tb/tb_idli_sqi_shift_m.sv
// Bench for idli_sqi_shift_m: queue-based transaction model checked every cycle plus literal vectors.
module tb_idli_sqi_shift_m;

`ifdef IDLI_SQI_SHIFT_TURN_EN
  localparam int TB_TURN = 2;
`else
  localparam int TB_TURN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic        big = 1'b0;
  logic [1:0]  len = 2'd0;
  logic [15:0] pdata_in = 16'h0;
  logic [3:0]  sio_in = 4'h0;
  logic        stall = 1'b0;
  logic [3:0]  o_sio;
  logic        o_oe;
  logic        o_ready;
  logic        o_done;
  logic [15:0] o_pdata;

  int total = 0;
  int bad   = 0;

  idli_sqi_shift_m #(
    .DATA_W   (16),
    .TURN_CYC (2)
  ) dut (
    .i_sqr_gck    (clk),
    .i_sqr_rst    (rst),
    .i_sqr_start  (start),
    .i_sqr_dir    (dir),
    .i_sqr_big    (big),
    .i_sqr_len    (len),
    .i_sqr_pdata  (pdata_in),
    .i_sqr_sio    (sio_in),
    .i_sqr_stall  (stall),
    .o_sqr_sio    (o_sio),
    .o_sqr_sio_oe (o_oe),
    .o_sqr_ready  (o_ready),
    .o_sqr_done   (o_done),
    .o_sqr_pdata  (o_pdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Transaction model: nibbles still to send, nibbles received so far, turnaround left.
  logic [3:0]  m_txq[$];
  logic [3:0]  m_rxq[$];
  bit          m_busy = 0;
  bit          m_tx = 0;
  bit          m_big = 0;
  int          m_n = 0;
  int          m_turn = 0;
  logic [15:0] m_val;
  logic        exp_ready = 1'b1;
  logic        exp_oe = 1'b0;
  logic [3:0]  exp_sio = 4'h0;
  logic        exp_done = 1'b0;
  logic [15:0] exp_pdata = 16'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0;
      m_turn = 0;
      m_txq.delete();
      m_rxq.delete();
      exp_done  = 1'b0;
      exp_pdata = 16'h0;
    end else begin
      exp_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1;
          m_tx   = dir;
          m_big  = big;
          m_n    = int'(len) + 1;
          m_turn = dir ? 0 : TB_TURN;
          m_txq.delete();
          m_rxq.delete();
          for (int k = 0; k < m_n; k++)
            m_txq.push_back(big ? pdata_in[4*(m_n-1-k) +: 4] : pdata_in[4*k +: 4]);
        end
      end else if (!stall) begin
        if (m_turn > 0) begin
          m_turn--;
        end else if (m_tx) begin
          void'(m_txq.pop_front());
          if (m_txq.size() == 0) begin
            m_busy   = 0;
            exp_done = 1'b1;
          end
        end else begin
          m_rxq.push_back(sio_in);
          if (m_rxq.size() == m_n) begin
            m_val = 16'h0;
            for (int k = 0; k < m_n; k++) begin
              if (m_big) m_val = (m_val << 4) | 16'(m_rxq[k]);
              else       m_val = m_val | (16'(m_rxq[k]) << (4*k));
            end
            exp_pdata = m_val;
            m_busy    = 0;
            exp_done  = 1'b1;
          end
        end
      end
    end
    exp_ready = !m_busy;
    exp_oe    = m_busy && m_tx;
    exp_sio   = exp_oe ? m_txq[0] : 4'h0;
  end

  always @(negedge clk) begin
    chk("model_ready", 16'(o_ready), 16'(exp_ready));
    chk("model_oe",    16'(o_oe),    16'(exp_oe));
    chk("model_sio",   16'(o_sio),   16'(exp_sio));
    chk("model_done",  16'(o_done),  16'(exp_done));
    chk("model_pdata", o_pdata,      exp_pdata);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Receive with literal nibble sequence (first nibble in seq[15:12]).
  task automatic rx_lit(input logic b, input logic [1:0] l, input logic [15:0] seq,
                        input logic [15:0] want);
    int n = int'(l) + 1;
    start = 1'b1; dir = 1'b0; big = b; len = l;
    for (int c = 1; c <= TB_TURN + n; c++) begin
      cyc();
      start = 1'b0;
      chk("rx_oe_low", 16'(o_oe), 16'h0);
      sio_in = (c > TB_TURN) ? seq[15 - 4*(c-TB_TURN-1) -: 4] : 4'hF;
    end
    cyc();
    chk("rx_done", 16'(o_done), 16'h1);
    chk("rx_pdata", o_pdata, want);
  endtask

  typedef struct packed {
    logic        d;
    logic        b;
    logic [1:0]  l;
    logic [15:0] pd;
    logic [15:0] stl;
  } vec_t;

  vec_t vecs [8];

  task automatic run_txn(input vec_t v);
    bit seen = 0;
    start = 1'b1; dir = v.d; big = v.b; len = v.l; pdata_in = v.pd;
    for (int i = 1; i <= 40 && !seen; i++) begin
      cyc();
      seen = o_done;
      start  = (i == 1);
      dir    = ~v.d;
      stall  = v.stl[i % 16];
      sio_in = v.pd[4*(i%4) +: 4];
    end
    start = 1'b0;
    stall = 1'b0;
    chk("txn_done_seen", 16'(seen), 16'h1);
  endtask

  logic [3:0] seq_b [4];
  logic [3:0] seq_l [4];
  logic [3:0] seq_s [5];

  initial begin
    seq_b = '{4'hA, 4'h5, 4'hC, 4'h3};
    seq_l = '{4'h3, 4'hC, 4'h5, 4'hA};
    seq_s = '{4'hA, 4'h5, 4'h5, 4'hC, 4'h3};
    vecs = '{
      '{1'b1, 1'b1, 2'd3, 16'hBEEF, 16'h0000},
      '{1'b0, 1'b0, 2'd3, 16'h1357, 16'h0012},
      '{1'b0, 1'b1, 2'd2, 16'h0ABC, 16'h0005},
      '{1'b1, 1'b0, 2'd1, 16'h00F0, 16'h0006},
      '{1'b0, 1'b1, 2'd0, 16'h00C0, 16'h0002},
      '{1'b1, 1'b1, 2'd0, 16'h0009, 16'h0000},
      '{1'b0, 1'b1, 2'd3, 16'hF00D, 16'h00A4},
      '{1'b1, 1'b0, 2'd3, 16'h4321, 16'h0108}
    };

    cyc();
    cyc();
    chk("rst_ready", 16'(o_ready), 16'h1);
    chk("rst_done",  16'(o_done),  16'h0);
    chk("rst_oe",    16'(o_oe),    16'h0);
    chk("rst_sio",   16'(o_sio),   16'h0);
    chk("rst_pdata", o_pdata,      16'h0);
    rst = 1'b0;

    // Big-endian transmit, then back-to-back little-endian transmit from the done cycle.
    start = 1'b1; dir = 1'b1; big = 1'b1; len = 2'd3; pdata_in = 16'hA5C3;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      start = 1'b0;
      chk("tx_big_sio", 16'(o_sio), 16'(seq_b[c-1]));
      chk("tx_big_oe",  16'(o_oe),  16'h1);
    end
    cyc();
    chk("tx_big_done", 16'(o_done), 16'h1);
    start = 1'b1; big = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      if (c == 1) chk("b2b_ready_low", 16'(o_ready), 16'h0);
      start = 1'b0;
      chk("tx_lit_sio", 16'(o_sio), 16'(seq_l[c-1]));
    end
    cyc();
    chk("tx_lit_done", 16'(o_done), 16'h1);
    cyc();
    chk("done_one_cycle", 16'(o_done), 16'h0);

    rx_lit(1'b1, 2'd1, 16'h7E00, 16'h007E);
    cyc();
    rx_lit(1'b0, 2'd1, 16'h7E00, 16'h00E7);
    cyc();

    // Transmit with one stall: the second nibble is held for two cycles.
    start = 1'b1; dir = 1'b1; big = 1'b1; len = 2'd3; pdata_in = 16'hA5C3;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      start = 1'b0;
      chk("tx_stall_sio", 16'(o_sio), 16'(seq_s[c-1]));
      stall = (c == 2);
    end
    cyc();
    chk("tx_stall_done", 16'(o_done), 16'h1);
    chk("tx_keeps_pdata", o_pdata, 16'h00E7);
    cyc();

    // Reset in the middle of a receive discards it.
    start = 1'b1; dir = 1'b0; big = 1'b1; len = 2'd3;
    cyc();
    start = 1'b0; sio_in = 4'h1;
    cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_done",  16'(o_done),  16'h0);
    chk("midrst_ready", 16'(o_ready), 16'h1);
    chk("midrst_pdata", o_pdata,      16'h0);
    chk("midrst_oe",    16'(o_oe),    16'h0);
    rst = 1'b0;
    rx_lit(1'b1, 2'd3, 16'h1234, 16'h1234);
    cyc();
    rx_lit(1'b1, 2'd0, 16'h9000, 16'h0009);
    cyc();

    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v]);
      cyc();
    end

    rst = 1'b1; start = 1'b1; dir = 1'b1;
    cyc();
    chk("rst_over_start_ready", 16'(o_ready), 16'h1);
    chk("rst_over_start_oe",    16'(o_oe),    16'h0);
    rst = 1'b0; start = 1'b0;
    cyc();
    chk("idle_after_rst", 16'(o_ready), 16'h1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
